seq_mul_arbiter: RTL and testbench

Shares one shift-add sequential multiplier among NUM_REQ requesters. The block arbitrates requests round-robin, sequences the WIDTH-cycle shift-add datapath, and returns the product tagged with the requester index over a valid/ready response channel. It replaces per-requester multiplier instances wherever several producers need occasional WIDTH x WIDTH unsigned products.

---
 rtl/seq_mul_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/seq_mul_arbiter.sv | 124 ++++++++++++
 tb/tb_seq_mul_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_arb_pkg.sv
// Shared types and defaults for the shared shift-add multiplier arbiter.
package seq_mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 4;

  // (base + off) mod n, valid while both terms are already below n.
  function automatic int wrap_add(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter
  import seq_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               found
);

  always_comb begin
    logic [ID_W-1:0] idx;
    // NOTE: every output and temporary gets a default before the loop so no path infers a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = ID_W'(wrap_add(int'(ptr), off, NUM_REQ));
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_mul_arbiter.sv
// One shift-add multiplier shared round-robin among NUM_REQ requesters.
// Define SEQ_MUL_ARB_EARLY_DONE_EN to skip the MUL phase when an operand is zero.
module seq_mul_arbiter
  import seq_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]       rsp_prod,
  output logic                     busy
);

  localparam int PW    = 2*WIDTH + 1;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_q;
  logic [PW-1:0]      p_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ID_W-1:0]    id_q;
  logic [ID_W-1:0]    ptr_q;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic               accept, zero_op, last_step;
  logic [WIDTH:0]     sum;
  logic [PW-1:0]      p_step;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .found     (grant_any)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef SEQ_MUL_ARB_EARLY_DONE_EN
  assign zero_op = (sel_a == '0) || (sel_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign accept    = (state == IDLE) && grant_any;
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // Add A into the upper half (carry lands in the extra top bit), then shift.
  assign sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
  assign p_step = p_q[0] ? ({sum, p_q[WIDTH-1:0]} >> 1) : (p_q >> 1);

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        req_ready = grant;
        if (grant_any) state_nxt = zero_op ? DONE : MUL;
      end
      MUL:  if (last_step) state_nxt = DONE;
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_id   = (state == DONE) ? id_q : '0;
  assign rsp_prod = (state == DONE) ? p_q[2*WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    // NOTE: the datapath is cleared by reset too, so an abandoned product cannot reappear later.
    if (reset) begin
      a_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
      id_q  <= '0;
      ptr_q <= '0;
    end else if (accept) begin
      a_q   <= sel_a;
      p_q   <= zero_op ? '0 : {{(WIDTH+1){1'b0}}, sel_b};
      cnt_q <= '0;
      id_q  <= grant_idx;
      ptr_q <= ID_W'(wrap_add(int'(grant_idx), 1, NUM_REQ));
    end else if (state == MUL) begin
      p_q   <= p_step;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_mul_arbiter.sv
// Self-checking bench for seq_mul_arbiter: vector table plus scoreboard.
module tb_seq_mul_arbiter;

  localparam int N    = 4;
  localparam int W    = 4;
  localparam int ID_W = 2;

  logic               clk;
  logic               reset;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*W-1:0]     req_a;
  logic [N*W-1:0]     req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [2*W-1:0]     rsp_prod;
  logic               busy;

  typedef struct {
    int id;
    int a;
    int b;
    int prod;
  } vec_t;

  typedef struct {
    int id;
    int prod;
    int acc_edge;
    int lat;
  } sb_t;

  sb_t  sb[$];
  int   rsp_log[$];
  int   exp_prod[N];
  int   exp_lat[N];
  int   acc_edge_of[N];
  int   hs_edge_of[N];
  int   n_vec, n_fail, n_rsp, n_acc, cyc;
  logic prev_rv;

  seq_mul_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(ID_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat_of(input int a, input int b);
`ifdef SEQ_MUL_ARB_EARLY_DONE_EN
    if (a == 0 || b == 0) return 1;
`endif
    return W;
  endfunction

  // One clock: observe at negedge, advance one posedge, retire accepted requests.
  task automatic cycle();
    logic [N-1:0] acc;
    sb_t          e;
    @(negedge clk);
    acc = '0;
    if (reset) begin
      sb.delete();
      prev_rv = 1'b0;
    end else begin
      acc = req_valid & req_ready;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          sb.push_back('{id: i, prod: exp_prod[i], acc_edge: cyc + 1, lat: exp_lat[i]});
          acc_edge_of[i] = cyc + 1;
          n_acc++;
        end
      end
      if (rsp_valid && !prev_rv) begin
        if (sb.size() == 0) check("rsp_unexpected", 1, 0);
        else                check("latency", cyc - sb[0].acc_edge, sb[0].lat);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          check("rsp_id", 32'(rsp_id), e.id);
          check("rsp_prod", 32'(rsp_prod), e.prod);
        end
        rsp_log.push_back(int'(rsp_id));
        hs_edge_of[rsp_id] = cyc + 1;
        n_rsp++;
      end
      prev_rv = rsp_valid;
    end
    @(posedge clk);
    cyc++;
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic drive(input int id, input int a, input int b, input int prod);
    req_a[id*W +: W] = a[W-1:0];
    req_b[id*W +: W] = b[W-1:0];
    exp_prod[id]     = prod;
    exp_lat[id]      = lat_of(a, b);
    req_valid[id]    = 1'b1;
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int t;
    t = 0;
    while (n_rsp < target && t < budget) begin
      cycle();
      t++;
    end
    if (n_rsp < target) check("rsp_timeout", n_rsp, target);
  endtask

  task automatic do_reset();
    req_valid = '0;
    reset     = 1'b1;
    cycle();
    cycle();
    reset     = 1'b0;
  endtask

  initial begin
    vec_t vecs[6];
    int   base, t;

    vecs[0] = '{id: 2, a: 13, b: 11, prod: 143};
    vecs[1] = '{id: 1, a: 15, b: 15, prod: 225};
    vecs[2] = '{id: 0, a: 0,  b: 9,  prod: 0};
    vecs[3] = '{id: 3, a: 7,  b: 9,  prod: 63};
    vecs[4] = '{id: 1, a: 1,  b: 1,  prod: 1};
    vecs[5] = '{id: 2, a: 15, b: 1,  prod: 15};

    n_vec = 0; n_fail = 0; n_rsp = 0; n_acc = 0; cyc = 0;
    prev_rv   = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    reset     = 1'b1;
    for (int i = 0; i < N; i++) begin
      exp_prod[i] = 0; exp_lat[i] = W; acc_edge_of[i] = 0; hs_edge_of[i] = 0;
    end

    do_reset();
    check("reset_req_ready", 32'(req_ready), 0);
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    check("reset_rsp_id",    32'(rsp_id),    0);
    check("reset_rsp_prod",  32'(rsp_prod),  0);
    check("reset_busy",      32'(busy),      0);

    for (int v = 0; v < 6; v++) begin
      drive(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].prod);
      wait_rsp(n_rsp + 1, 40);
    end

    // All four at once from reset: pointer alone orders them, twice over.
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) do_reset();
      rsp_log.delete();
      base = n_rsp;
      for (int i = 0; i < N; i++) drive(i, i + 1, 3, (i + 1) * 3);
      wait_rsp(base + N, 80);
      for (int i = 0; i < N; i++)
        check("rr_order", (i < rsp_log.size()) ? rsp_log[i] : -1, i);
    end

    // Backpressure: response held, no grants while DONE, accept one cycle after handshake.
    rsp_ready = 1'b0;
    drive(1, 5, 6, 30);
    t = 0;
    while (!rsp_valid && t < 20) begin
      cycle();
      t++;
    end
    check("bp_rsp_valid_seen", 32'(rsp_valid), 1);
    drive(3, 2, 2, 4);
    for (int k = 0; k < 10; k++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 1);
      check("bp_rsp_id",    32'(rsp_id),    1);
      check("bp_rsp_prod",  32'(rsp_prod),  30);
      check("bp_req_ready", 32'(req_ready), 0);
      check("bp_busy",      32'(busy),      1);
      cycle();
    end
    rsp_ready = 1'b1;
    base = n_rsp;
    wait_rsp(base + 2, 40);
    check("bp_next_accept", acc_edge_of[3], hs_edge_of[1] + 1);

    // Reset during the second MUL cycle abandons the product.
    base = n_acc;
    drive(0, 12, 10, 120);
    t = 0;
    while (n_acc <= base && t < 20) begin
      cycle();
      t++;
    end
    check("abort_accepted", n_acc, base + 1);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("abort_busy",      32'(busy),      0);
    check("abort_rsp_valid", 32'(rsp_valid), 0);
    base = n_rsp;
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("abort_no_rsp", 32'(rsp_valid), 0);
    end
    check("abort_rsp_count", n_rsp, base);
    drive(0, 7, 9, 63);
    wait_rsp(base + 1, 40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
